// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/flush controller: instruction pair and taken-branch
// in, stall/flush/bubble controls and performance counters out.
interface hazard_stall_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             i_taken_branch;
  logic [XLEN-1:0]  i_if_id_instr;
  logic [XLEN-1:0]  i_id_ex_instr;
  logic             o_stall_if;
  logic             o_stall_id;
  logic             o_bubble_ex;
  logic             o_flush_if_id;
  logic             o_flush_id_ex;
  logic             o_busy;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_flush_events;

  modport master (
    output i_taken_branch, i_if_id_instr, i_id_ex_instr,
    input  o_stall_if, o_stall_id, o_bubble_ex, o_flush_if_id, o_flush_id_ex,
    input  o_busy, o_stall_cycles, o_flush_events
  );

  modport slave (
    input  i_taken_branch, i_if_id_instr, i_id_ex_instr,
    output o_stall_if, o_stall_id, o_bubble_ex, o_flush_if_id, o_flush_id_ex,
    output o_busy, o_stall_cycles, o_flush_events
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage RV32I pipeline.
// Optional saturating stall/flush counters are built only when HZ_PERF_CNT_EN is defined.
module hazard_stall_unit #(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  hazard_stall_unit_if.slave  hz
);
  localparam int CW = $clog2(LOAD_LAT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {IDLE, STALL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] prod_w, cons_w;
  logic [6:0]      p_op, c_op;
  logic [4:0]      p_rd, c_rs1, c_rs2;
  logic            prod_ld, use_rs1, use_rs2, hit;
  logic            stall, stall_o, flush_o;
  logic            unused_fields;

  assign prod_w = hz.i_id_ex_instr;
  assign cons_w = hz.i_if_id_instr;
  assign p_op   = prod_w[6:0];
  assign p_rd   = prod_w[11:7];
  assign c_op   = cons_w[6:0];
  assign c_rs1  = cons_w[19:15];
  assign c_rs2  = cons_w[24:20];
  assign unused_fields = ^{prod_w[XLEN-1:12], cons_w[XLEN-1:25], cons_w[14:7]};

  // Only genuine register reads count, so immediates that alias rs1/rs2 never stall
  assign prod_ld = (p_op == OP_LOAD) && (p_rd != 5'd0);
  assign use_rs1 = (c_op != OP_LUI) && (c_op != OP_AUIPC) && (c_op != OP_JAL);
  assign use_rs2 = (c_op == OP_OP) || (c_op == OP_STORE) || (c_op == OP_BRANCH);
  assign hit     = prod_ld && ((use_rs1 && (c_rs1 == p_rd)) || (use_rs2 && (c_rs2 == p_rd)));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // First stall cycle is Mealy from IDLE; the remaining LOAD_LAT-1 come from STALL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (hz.i_taken_branch) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = CW'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall_o = stall && i_rst;
  assign flush_o = hz.i_taken_branch && i_rst;

  assign hz.o_stall_if    = stall_o;
  assign hz.o_stall_id    = stall_o;
  assign hz.o_bubble_ex   = stall_o;
  assign hz.o_flush_if_id = flush_o;
  assign hz.o_flush_id_ex = flush_o;
  assign hz.o_busy        = (state_q == STALL);

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall_o);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_o);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.o_stall_cycles = stall_cnt_q;
  assign hz.o_flush_events = flush_cnt_q;
`else
  assign hz.o_stall_cycles = {CNT_W{1'b0}};
  assign hz.o_flush_events = {CNT_W{1'b0}};
`endif
endmodule
